// File: rtl/axi_burst_responder.sv
`timescale 1ns/1ps
// AXI4 INCR burst responder backed by a word-addressed array; serves cache refill and eviction bursts.
// Define MEM_RESP_THROTTLE_EN to stall one cycle after every R/W beat (half throughput).
//   state     | meaning
//   S_IDLE    | address channels open, write wins a tie
//   S_RD      | streaming read beats
//   S_WR      | accepting write beats
//   S_WR_RESP | holding bvalid until bready
module axi_burst_responder #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int MEM_DEPTH = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_W / 8;
  localparam int HI_LSB = 3 + IDX_W;

`ifdef MEM_RESP_THROTTLE_EN
  localparam logic THROTTLE = 1'b1;
`else
  localparam logic THROTTLE = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD      = 2'd1;
  localparam logic [1:0] S_WR      = 2'd2;
  localparam logic [1:0] S_WR_RESP = 2'd3;

  logic [1:0]        state;
  logic              addr_rdy;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  next_idx;
  logic [7:0]        len;
  logic [7:0]        beat;
  logic [7:0]        next_beat;
  logic              oor;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]  ar_idx;
  logic [IDX_W-1:0]  aw_idx;
  logic              ar_oor;
  logic              aw_oor;
  logic              ar_hs;
  logic              aw_hs;
  logic              r_hs;
  logic              w_hs;
  logic              b_hs;
  logic              w_count_end;
  logic              w_end;
  logic              mem_we;
  logic              unused_addr_lsbs;

  assign ar_idx    = araddr[3 +: IDX_W];
  assign aw_idx    = awaddr[3 +: IDX_W];
  assign ar_oor    = |araddr[ADDR_W-1:HI_LSB];
  assign aw_oor    = |awaddr[ADDR_W-1:HI_LSB];
  assign unused_addr_lsbs = ^{araddr[2:0], awaddr[2:0]};

  // A pending write masks arready so an eviction always lands before its refill.
  assign awready   = addr_rdy;
  assign arready   = addr_rdy & ~awvalid;

  assign ar_hs     = arvalid & arready;
  assign aw_hs     = awvalid & awready;
  assign r_hs      = rvalid & rready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & bready;

  assign next_idx    = idx + 1'b1;
  assign next_beat   = beat + 8'd1;
  assign w_count_end = (beat == len);
  assign w_end       = wlast | w_count_end;
  assign mem_we      = w_hs & ~oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_rdy <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rdata    <= '0;
      rresp    <= 2'd0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= 2'd0;
      idx      <= '0;
      len      <= 8'd0;
      beat     <= 8'd0;
      oor      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_rdy <= 1'b1;
          if (aw_hs) begin
            state    <= S_WR;
            addr_rdy <= 1'b0;
            idx      <= aw_idx;
            len      <= awlen;
            beat     <= 8'd0;
            oor      <= aw_oor;
            wready   <= 1'b1;
          end else if (ar_hs) begin
            state    <= S_RD;
            addr_rdy <= 1'b0;
            idx      <= ar_idx;
            len      <= arlen;
            beat     <= 8'd0;
            oor      <= ar_oor;
            rvalid   <= 1'b1;
            rdata    <= ar_oor ? '0 : mem[ar_idx];
            rresp    <= ar_oor ? 2'd3 : 2'd0;
            rlast    <= (arlen == 8'd0);
          end
        end
        S_RD: begin
          if (r_hs) begin
            if (rlast) begin
              state    <= S_IDLE;
              addr_rdy <= 1'b1;
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
            end else begin
              idx    <= next_idx;
              beat   <= next_beat;
              rdata  <= oor ? '0 : mem[next_idx];
              rlast  <= (next_beat == len);
              rvalid <= ~THROTTLE;
            end
          end else if (!rvalid) begin
            rvalid <= 1'b1;
          end
        end
        S_WR: begin
          if (w_hs) begin
            if (w_end) begin
              state  <= S_WR_RESP;
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= oor ? 2'd3 : ((wlast != w_count_end) ? 2'd2 : 2'd0);
            end else begin
              idx    <= next_idx;
              beat   <= next_beat;
              wready <= ~THROTTLE;
            end
          end else if (!wready) begin
            wready <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (b_hs) begin
            state    <= S_IDLE;
            addr_rdy <= 1'b1;
            bvalid   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Contents survive reset so beats written before an abort stay visible.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
